// File: rtl/clk_switch_ctrl.sv
// Arbitrated select sequencer for a glitch-free two-source clock mux.
// Two requesters take turns; each real source change is followed by a settle period and then a dwell lockout.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | arbitrating pending requests; same-source requests acked here
// SETTLE | selection just changed, waiting for the mux output to settle
// DWELL  | lockout after an acknowledged switch, requests stay pending
module clk_switch_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int DWELL_CYCLES  = 64
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_sel,
    output logic [1:0]  req_ack,
    output logic        selection,
    output logic        busy,
    output logic        done,
    output logic [15:0] switch_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] DWELL_LOAD  = (DWELL_CYCLES > 0) ? 8'(DWELL_CYCLES - 1) : 8'd0;

    state_t      state;
    logic [7:0]  cnt;
    logic        rr;
    logic        gnt;
    logic [15:0] switch_cnt_q;

    logic [1:0]  eligible;
    logic        any_req;
    logic        pick;
    logic        pick_sel;
    logic        need_switch;
    logic        cnt_inc;

    assign switch_cnt = switch_cnt_q;

    // A requester whose ack is on the wire this cycle is excluded so it cannot be acked twice.
    always_comb begin
        eligible    = req_valid & ~req_ack;
        any_req     = |eligible;
        pick        = (eligible == 2'b11) ? rr : eligible[1];
        pick_sel    = req_sel[pick];
        need_switch = (state == IDLE) && any_req && (pick_sel != selection);
        cnt_inc     = need_switch && (switch_cnt_q != 16'hFFFF);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            rr           <= 1'b0;
            gnt          <= 1'b0;
            selection    <= 1'b0;
            req_ack      <= 2'b00;
            done         <= 1'b0;
            busy         <= 1'b0;
            switch_cnt_q <= 16'd0;
        end else begin
            req_ack      <= 2'b00;
            done         <= 1'b0;
            switch_cnt_q <= switch_cnt_q + {15'd0, cnt_inc};
            case (state)
                IDLE: begin
                    if (any_req) begin
                        rr <= ~pick;
                        if (need_switch) begin
                            selection <= pick_sel;
                            gnt       <= pick;
                            cnt       <= SETTLE_LOAD;
                            state     <= SETTLE;
                            busy      <= 1'b1;
                        end else begin
                            req_ack[pick] <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == 8'd0) begin
                        req_ack[gnt] <= 1'b1;
                        done         <= 1'b1;
                        if (DWELL_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DWELL;
                            cnt   <= DWELL_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DWELL: begin
                    if (cnt == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
Parameters (one per line: name, default, meaning):
REQ-001: SETTLE_CYCLES, 16, cycles selection is held before the switch is acknowledged; legal range 1..255.
REQ-002: DWELL_CYCLES, 64, lockout cycles after an acknowledged switch before another grant; legal range 0..255.
Ports (one per line: name  direction  width  meaning):
REQ-003: aclk  input  1  single clock; all logic on its rising edge.
REQ-004: areset  input  1  synchronous, active-high reset.
REQ-005: req_valid  input  2  per-requester switch request; bit i belongs to requester i.
REQ-006: req_sel  input  2  per-requester target source; bit i is requester i's target (0 = aclk_in1, 1 = aclk_in2).
REQ-007: req_ack  output  2  one-cycle completion pulse per requester.
REQ-008: selection  output  1  registered select driven to the glitch-free clock mux.
REQ-009: busy  output  1  high whenever the state is not IDLE.
REQ-010: done  output  1  one-cycle pulse when a real source change completes settling.
REQ-011: switch_cnt  output  16  count of real selection changes, saturating.

Function
REQ-012: The FSM shall have states IDLE, SETTLE and DWELL.
REQ-013: Requester i shall hold req_valid[i] high and req_sel[i] stable until it sees req_ack[i]; the block does not sample req_sel[i] at any other time.
REQ-014: In IDLE, eligible requesters shall be those with req_valid[i]=1 and req_ack[i]=0 in the same cycle; this prevents a double acknowledge.
REQ-015: Arbitration shall be round-robin with a 1-bit pointer rr (reset 0 = requester 0 first); with both eligible, rr picks; with one eligible, that one wins. rr shall point to the other requester after every grant.
REQ-016: If the granted target equals selection, req_ack[g] shall pulse in the next cycle, state stays IDLE, and selection, done and switch_cnt are unchanged.
REQ-017: If the target differs, at the next edge selection shall take req_sel[g], state shall go to SETTLE, and the counter shall load SETTLE_CYCLES-1.
REQ-018: SETTLE shall last exactly SETTLE_CYCLES cycles; req_ack[g] and done shall be high in the first cycle after SETTLE, i.e. SETTLE_CYCLES cycles after selection changes.
REQ-019: After SETTLE, the state shall be DWELL for DWELL_CYCLES cycles, starting with the ack cycle. If DWELL_CYCLES=0, the state shall go directly to IDLE with the ack.
REQ-020: Requests arriving in SETTLE or DWELL shall stay pending, unacknowledged, and be arbitrated in the first IDLE cycle.
REQ-021: selection shall change only on the IDLE->SETTLE transition, so at most one change occurs per SETTLE_CYCLES+DWELL_CYCLES+1 cycles.
REQ-022: switch_cnt shall increment by 1 on each IDLE->SETTLE transition and hold at 0xFFFF.
REQ-023: If req_valid drops before ack (protocol violation), the in-flight switch shall still complete and the ack pulse shall still be issued.
REQ-024: If both requesters target the same new source, the first grant shall switch; the second shall then be acked per REQ-016 without a change.
REQ-025: The counter shall be 8 bits wide; the design shall not compare or load values wider than 8 bits.

Reset
REQ-026: While areset=1 at an edge: state=IDLE, selection=0, req_ack=00, done=0, busy=0, switch_cnt=0, rr=0, counter=0.
REQ-027: Reset in SETTLE or DWELL shall abort the sequence with no ack or done pulse, and selection shall return to 0 at that edge.

Verification (bench with SETTLE_CYCLES=4, DWELL_CYCLES=8)
REQ-028: req_valid=01, req_sel=01 in IDLE (selection=0) -> selection=1 next cycle; busy=1; req_ack=01 and done=1 exactly 4 cycles later; busy drops after 8 more cycles; switch_cnt=1.
REQ-029: selection=1, req_valid=10, req_sel=10 -> req_ack=10 the next cycle; selection, switch_cnt and busy unchanged; no done pulse.
REQ-030: Both valid in the same cycle, rr=0, req_sel=10 from selection=0 -> requester 0 is acked immediately (no change); requester 1 is granted next IDLE cycle, selection=1, acked 4 cycles later.
REQ-031: Request from requester 1 during DWELL -> no ack until DWELL ends; granted in the first IDLE cycle; total gap between the two selection changes = 13 cycles.
REQ-032: areset pulsed in the 2nd SETTLE cycle after switching to 1 -> selection=0, busy=0, no req_ack or done pulse, switch_cnt=0.
REQ-033: Force switch_cnt near saturation (0xFFFE) and do 3 real switches -> switch_cnt=0xFFFF and remains there.
